// File: rtl/ym3438_dbg_capture_pkg.sv
// Shared types and elaboration helpers for the debug readout capture block.
package ym3438_dbg_capture_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cap_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

    // Word index field never collapses to zero width, even for single-word frames.
    function automatic int idx_width(input int words);
        return (clog2(words) < 1) ? 1 : clog2(words);
    endfunction

    function automatic int frame_bits(input int data_width, input int words);
        return data_width * words;
    endfunction

endpackage

// File: rtl/ym3438_dbg_capture_if.sv
// Word handoff bus between the capture block (master) and the host/debug reader (slave).
interface ym3438_dbg_capture_if
    import ym3438_dbg_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WORDS      = 4
);
    localparam int IDX_W = idx_width(WORDS);

    logic [DATA_WIDTH-1:0] word_data;
    logic [IDX_W-1:0]      word_index;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output word_data,
        output word_index,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_index,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/ym3438_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; push while full succeeds only alongside a pop.
module ym3438_sync_fifo
    import ym3438_dbg_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4
) (
    input  logic                  MCLK,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the simultaneous pop frees.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ym3438_dbg_capture.sv
// Samples the serial debug chain on c1 strobes, reassembles frames into words
// and buffers them for a valid/ready reader.
module ym3438_dbg_capture
    import ym3438_dbg_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int WORDS      = 4,
    parameter int LSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic MCLK,
    input  logic reset_n,
    input  logic c1,
    input  logic enable,
    input  logic load,
    input  logic serial_in,
    ym3438_dbg_capture_if.master word_bus,
    output logic frame_done,
    output logic busy,
    output logic overflow,
    input  logic clear_overflow
);
    localparam int BIT_W   = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);
    localparam int IDX_W   = idx_width(WORDS);
    localparam int ENTRY_W = DATA_WIDTH + IDX_W;

    cap_state_t            state, state_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]      word_cnt, word_cnt_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n, shift_in;
    logic                  push, done_n, pop, drop, start;
    logic                  last_bit, last_word;
    logic                  fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    push_entry, head;

    assign start     = c1 && load && enable;
    assign last_bit  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign last_word = (word_cnt == IDX_W'(WORDS - 1));

    always_comb begin
        if (LSB_FIRST != 0) begin
            shift_in = {serial_in, shift_reg[DATA_WIDTH-1:1]};
        end else begin
            shift_in = {shift_reg[DATA_WIDTH-2:0], serial_in};
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            word_cnt   <= word_cnt_n;
            shift_reg  <= shift_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        word_cnt_n = word_cnt;
        shift_n    = shift_reg;
        push       = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                // Chain output is stale on the load edge, so nothing is sampled here.
                if (start) begin
                    state_n    = SHIFT;
                    bit_cnt_n  = '0;
                    word_cnt_n = '0;
                    shift_n    = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    bit_cnt_n  = '0;
                    word_cnt_n = '0;
                    shift_n    = '0;
                end else if (c1) begin
                    shift_n = shift_in;
                    if (last_bit) begin
                        push      = 1'b1;
                        bit_cnt_n = '0;
                        if (last_word) begin
                            done_n     = 1'b1;
                            word_cnt_n = '0;
                            state_n    = IDLE;
                        end else begin
                            word_cnt_n = word_cnt + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state == SHIFT);
    assign push_entry = {word_cnt, shift_in};
    assign pop        = word_bus.word_ready && !fifo_empty;
    assign drop       = push && fifo_full && !pop;

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    ym3438_sync_fifo #(
        .DATA_WIDTH(ENTRY_W),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .MCLK   (MCLK),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign word_bus.word_data  = head[DATA_WIDTH-1:0];
    assign word_bus.word_index = head[ENTRY_W-1:DATA_WIDTH];
    assign word_bus.word_valid = !fifo_empty;

endmodule
